mem_wb_elastic_reg: RTL and testbench

Parametrised successor to the fixed MEM/WB latch: an elastic, valid/ready pipeline register between the data-memory stage and writeback. It holds up to two in-flight instructions (main slot plus skid slot), captures late-arriving load data on `dhit`, and supports synchronous flush. It lets the memory stage advance independently of writeback stalls, which the plain enable/flush latch cannot do.

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/memwb_slot.sv | 42 ++++
 rtl/mem_wb_elastic_reg.sv | 131 +++++++++++++
 tb/tb_mem_wb_elastic_reg.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: the MEM/WB payload bundle and elastic-register occupancy.
package cpu_types_pkg;

  typedef struct packed {
    logic [31:0] pc_inc;
    logic [31:0] result;
    logic [4:0]  rw;
    logic        write_reg;
    logic        mem_to_reg;
    logic [1:0]  rwd_sel;
    logic [5:0]  opcode;
  } memwb_payload_t;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_ONE,
    OCC_TWO
  } memwb_occ_t;

  localparam int MEMWB_PAYLOAD_W = $bits(memwb_payload_t);

endpackage

// File: rtl/memwb_slot.sv
// One MEM/WB entry: valid, pending-load flag, payload and load data.
// Priority is reset, clear, load, then late data fill of a pending load.
module memwb_slot #(
  parameter int DATA_W    = 32,
  parameter int PAYLOAD_W = 79
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 load,
  input  logic [PAYLOAD_W-1:0] ld_payload,
  input  logic [DATA_W-1:0]    ld_data,
  input  logic                 ld_pend,
  input  logic                 fill,
  input  logic [DATA_W-1:0]    fill_data,
  output logic                 valid,
  output logic                 pend,
  output logic [PAYLOAD_W-1:0] payload,
  output logic [DATA_W-1:0]    data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid   <= 1'b0;
      pend    <= 1'b0;
      payload <= '0;
      data    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      pend  <= 1'b0;
    end else if (load) begin
      valid   <= 1'b1;
      pend    <= ld_pend;
      payload <= ld_payload;
      data    <= ld_data;
    end else if (fill && valid && pend) begin
      pend <= 1'b0;
      data <= fill_data;
    end
  end

endmodule

// File: rtl/mem_wb_elastic_reg.sv
// Elastic valid/ready MEM/WB register with late load-data capture and flush.
// MEMWB_SKID_EN adds a skid entry and a fully registered in_ready.
module mem_wb_elastic_reg
  import cpu_types_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PAYLOAD_W = MEMWB_PAYLOAD_W
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 in_is_load,
  input  logic                 dhit,
  input  logic [DATA_W-1:0]    dmemload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [DATA_W-1:0]    out_dmemload
);

  logic                 acc, pop, fill_now;
  logic                 n_pend;
  logic [DATA_W-1:0]    n_data;
  logic                 h_valid, h_pend, h_clear, h_load, h_ld_pend;
  logic [PAYLOAD_W-1:0] h_ld_payload;
  logic [DATA_W-1:0]    h_ld_data;

  assign out_valid = h_valid & ~h_pend;
  assign pop       = out_valid & out_ready;
  assign acc       = in_valid & in_ready;
  // A dhit in an accept cycle belongs to the accepted load, never to a held entry.
  assign fill_now  = dhit & ~acc;
  assign n_pend    = in_is_load & ~dhit;
  assign n_data    = (in_is_load & dhit) ? dmemload : '0;

`ifdef MEMWB_SKID_EN
  logic                 s_valid, s_pend, s_clear, s_load;
  logic [PAYLOAD_W-1:0] s_payload;
  logic [DATA_W-1:0]    s_data;
  logic                 s_mv_pend;
  logic [DATA_W-1:0]    s_mv_data;
  logic [1:0]           cnt_nxt;
  logic                 pend_nxt;
  logic                 ready_r;
  memwb_occ_t           occ_nxt;

  // Skid entry promoted to head picks up a fill arriving in the same cycle.
  assign s_mv_pend = s_pend & ~fill_now;
  assign s_mv_data = (s_pend & fill_now) ? dmemload : s_data;

  assign h_load  = (pop & (s_valid | acc)) | (~h_valid & acc);
  assign h_clear = flush | (pop & ~s_valid & ~acc);
  assign s_load  = acc & h_valid & (~pop | s_valid);
  assign s_clear = flush | (pop & ~s_load);

  always_comb begin
    h_ld_payload = in_payload;
    h_ld_data    = n_data;
    h_ld_pend    = n_pend;
    if (pop && s_valid) begin
      h_ld_payload = s_payload;
      h_ld_data    = s_mv_data;
      h_ld_pend    = s_mv_pend;
    end
  end

  always_comb begin
    cnt_nxt  = {1'b0, h_valid} + {1'b0, s_valid} + {1'b0, acc} - {1'b0, pop};
    pend_nxt = ~flush & (((h_pend | s_pend) & ~fill_now) | (acc & n_pend));
    occ_nxt  = OCC_EMPTY;
    if (!flush) begin
      case (cnt_nxt)
        2'd1:    occ_nxt = OCC_ONE;
        2'd2:    occ_nxt = OCC_TWO;
        default: occ_nxt = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) ready_r <= 1'b1;
    else     ready_r <= (occ_nxt != OCC_TWO) & ~pend_nxt;
  end

  // The flop holds the post-reset value; RST masks it while asserted.
  assign in_ready = ready_r & ~RST;

  memwb_slot #(.DATA_W(DATA_W), .PAYLOAD_W(PAYLOAD_W)) u_skid (
    .clk        (CLK),
    .rst        (RST),
    .clear      (s_clear),
    .load       (s_load),
    .ld_payload (in_payload),
    .ld_data    (n_data),
    .ld_pend    (n_pend),
    .fill       (fill_now),
    .fill_data  (dmemload),
    .valid      (s_valid),
    .pend       (s_pend),
    .payload    (s_payload),
    .data       (s_data)
  );
`else
  assign h_load       = acc;
  assign h_clear      = flush | (pop & ~acc);
  assign h_ld_payload = in_payload;
  assign h_ld_data    = n_data;
  assign h_ld_pend    = n_pend;
  assign in_ready     = ~RST & (~h_valid | pop);
`endif

  memwb_slot #(.DATA_W(DATA_W), .PAYLOAD_W(PAYLOAD_W)) u_head (
    .clk        (CLK),
    .rst        (RST),
    .clear      (h_clear),
    .load       (h_load),
    .ld_payload (h_ld_payload),
    .ld_data    (h_ld_data),
    .ld_pend    (h_ld_pend),
    .fill       (fill_now),
    .fill_data  (dmemload),
    .valid      (h_valid),
    .pend       (h_pend),
    .payload    (out_payload),
    .data       (out_dmemload)
  );

endmodule

// File: tb/tb_mem_wb_elastic_reg.sv
// Bench for mem_wb_elastic_reg: queue model plus directed vectors; adapts to MEMWB_SKID_EN.
module tb_mem_wb_elastic_reg;
  import cpu_types_pkg::*;

  localparam int DW = 32;
  localparam int PW = $bits(memwb_payload_t);
`ifdef MEMWB_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          flush = 1'b0, in_valid = 1'b0, in_is_load = 1'b0, dhit = 1'b0, out_ready = 1'b0;
  logic [PW-1:0] in_payload = '0;
  logic [DW-1:0] dmemload = '0;
  logic          in_ready, out_valid;
  logic [PW-1:0] out_payload;
  logic [DW-1:0] out_dmemload;

  mem_wb_elastic_reg dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload), .in_is_load(in_is_load),
    .dhit(dhit), .dmemload(dmemload),
    .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload), .out_dmemload(out_dmemload)
  );

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;
  int pop_pc[$];
  int pop_cyc[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: an ordered list of in-flight entries.
  typedef struct {
    logic [PW-1:0] p;
    logic [DW-1:0] d;
    bit            pend;
  } ent_t;
  ent_t q[$];

  function automatic bit m_out_valid();
    return (q.size() > 0) && !q[0].pend;
  endfunction

  function automatic bit m_any_pend();
    foreach (q[i]) if (q[i].pend) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_in_ready();
    if (RST) return 1'b0;
`ifdef MEMWB_SKID_EN
    return (q.size() < 2) && !m_any_pend();
`else
    return (q.size() == 0) || (m_out_valid() && out_ready);
`endif
  endfunction

  always @(posedge CLK) begin : model
    bit   acc, pop;
    ent_t e;
    cyc++;
    acc = in_valid && m_in_ready();
    pop = m_out_valid() && out_ready;
    if (RST || flush) q.delete();
    else begin
      if (dhit && !acc)
        foreach (q[i]) if (q[i].pend) begin q[i].pend = 1'b0; q[i].d = dmemload; end
      if (pop) void'(q.pop_front());
      if (acc) begin
        e.p = in_payload;
        e.d = (in_is_load && dhit) ? dmemload : '0;
        e.pend = in_is_load && !dhit;
        q.push_back(e);
      end
    end
  end

  always @(negedge CLK) begin : compare
    memwb_payload_t pl;
    if (cmp_en) begin
      chk("in_ready", in_ready, m_in_ready());
      chk("out_valid", out_valid, m_out_valid());
      if (m_out_valid()) begin
        chk("out_payload", out_payload, q[0].p);
        chk("out_dmemload", out_dmemload, q[0].d);
      end
      if (out_valid && out_ready) begin
        pl = out_payload;
        pop_pc.push_back(int'(pl.pc_inc));
        pop_cyc.push_back(cyc);
      end
    end
  end

  function automatic logic [PW-1:0] mk(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] rw);
    memwb_payload_t p;
    p = '0;
    p.pc_inc = pc;
    p.result = res;
    p.rw = rw;
    p.write_reg = 1'b1;
    p.opcode = pc[5:0];
    return p;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_is_load = 1'b0; dhit = 1'b0; flush = 1'b0;
  endtask

  initial begin
    memwb_payload_t pl;

    // Reset
    step();
    cmp_en = 1'b1;
    step(); step();
    @(negedge CLK);
    chk("rst_out_payload", out_payload, '0);
    chk("rst_out_dmemload", out_dmemload, '0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    step();
    RST = 1'b0;
    @(negedge CLK);
    chk("post_rst_in_ready", in_ready, 1'b1);

    // Single non-load
    step();
    in_valid = 1'b1; in_payload = mk(32'h4, 32'h0000_00AA, 5'd5); out_ready = 1'b1;
    step();
    idle();
    @(negedge CLK);
    pl = out_payload;
    chk("t1_out_valid", out_valid, 1'b1);
    chk("t1_result", pl.result, 32'h0000_00AA);
    chk("t1_rw", pl.rw, 5'd5);
    chk("t1_dmemload", out_dmemload, 32'h0);
    step();
    @(negedge CLK);
    chk("t1_empty_out_valid", out_valid, 1'b0);
    chk("t1_empty_in_ready", in_ready, 1'b1);

    // Back-to-back accepts against a stalled writeback
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_payload = mk(32'(100 + i), 32'(i), 5'd1);
      @(negedge CLK);
      chk("t2_in_ready", in_ready, (i < CAP));
      step();
    end
    idle();
    pop_pc.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("t2_drain_count", pop_pc.size(), CAP);
    for (int i = 0; i < CAP; i++) chk("t2_drain_order", pop_pc[i], 100 + i);

    // Load with data two cycles after accept
    in_valid = 1'b1; in_is_load = 1'b1; in_payload = mk(32'd200, 32'h0, 5'd2);
    step();
    idle();
    @(negedge CLK);
    chk("t3_pend_in_ready", in_ready, 1'b0);
    chk("t3_pend_out_valid", out_valid, 1'b0);
    step();
    dhit = 1'b1; dmemload = 32'hDEAD_BEEF;
    @(negedge CLK);
    chk("t3_pend2_in_ready", in_ready, 1'b0);
    step();
    idle();
    @(negedge CLK);
    chk("t3_fill_out_valid", out_valid, 1'b1);
    chk("t3_fill_data", out_dmemload, 32'hDEAD_BEEF);
    step();
    @(negedge CLK);
    chk("t3_after_in_ready", in_ready, 1'b1);

    // Load hitting in the accept cycle
    step();
    in_valid = 1'b1; in_is_load = 1'b1; dhit = 1'b1; dmemload = 32'h1234_5678;
    in_payload = mk(32'd210, 32'h0, 5'd3);
    step();
    idle();
    @(negedge CLK);
    chk("t4_out_valid", out_valid, 1'b1);
    chk("t4_data", out_dmemload, 32'h1234_5678);
    chk("t4_in_ready", in_ready, 1'b1);
    step();

    // Flush against accept, pop and dhit with one entry held
    out_ready = 1'b0;
    in_valid = 1'b1; in_payload = mk(32'd300, 32'h0, 5'd4);
    step();
    flush = 1'b1; in_valid = 1'b1; in_is_load = 1'b1; dhit = 1'b1; dmemload = 32'h5555_5555;
    in_payload = mk(32'd301, 32'h0, 5'd4); out_ready = 1'b1;
    step();
    idle();
    pop_pc.delete();
    @(negedge CLK);
    chk("t5_out_valid", out_valid, 1'b0);
    chk("t5_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 3; i++) step();
    chk("t5_no_pops", pop_pc.size(), 0);

    // Flush with the block full
    out_ready = 1'b0;
    for (int i = 0; i < CAP; i++) begin
      in_valid = 1'b1; in_payload = mk(32'(310 + i), 32'h0, 5'd6);
      step();
    end
    flush = 1'b1; in_valid = 1'b1; dhit = 1'b1; in_payload = mk(32'd320, 32'h0, 5'd6);
    step();
    idle();
    out_ready = 1'b1;
    pop_pc.delete();
    @(negedge CLK);
    chk("t5b_out_valid", out_valid, 1'b0);
    chk("t5b_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 3; i++) step();
    chk("t5b_no_pops", pop_pc.size(), 0);

    // Pending load behind a held entry, filled as the head pops
    out_ready = 1'b0;
    in_valid = 1'b1; in_payload = mk(32'd400, 32'h7, 5'd7);
    step();
    in_valid = 1'b1; in_is_load = 1'b1; in_payload = mk(32'd401, 32'h0, 5'd8);
    step();
    idle();
    out_ready = 1'b1; dhit = 1'b1; dmemload = 32'h0000_0077;
    step();
    idle();
    for (int i = 0; i < 3; i++) step();

    // Continuous stream of eight non-loads
    pop_pc.delete(); pop_cyc.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_payload = mk(32'(500 + i), 32'(i * 3), 5'(i));
      step();
    end
    idle();
    for (int i = 0; i < 3; i++) step();
    chk("t7_pop_count", pop_pc.size(), 8);
    if (pop_pc.size() == 8) begin
      chk("t7_consecutive", pop_cyc[7] - pop_cyc[0], 7);
      chk("t7_first_pc", pop_pc[0], 500);
      chk("t7_last_pc", pop_pc[7], 507);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
